std_mem_copy_d1: RTL

Sequential initiator for the one-dimensional memory port protocol. On a `go` pulse it reads `len` consecutive words from a source memory through its combinational read port and writes them to a destination memory through its write-enable/done handshake. When all words are written it pulses `done` once. It sits between two `std_mem_d1` instances as a copy/DMA engine driven by a Calyx control FSM.

---
 rtl/std_mem_copy_d1.sv | 116 +++++++++++
 1 files changed

// File: rtl/std_mem_copy_d1.sv
// Word-by-word copy engine between two std_mem_d1 memories: READ, WRITE, WAIT per word, then a done pulse.
// Define STD_MEM_COPY_CHECKS_EN to compile in simulation-only protocol checks.
module std_mem_copy_d1 #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] src_base,
  input  logic [IDX_SIZE-1:0] dst_base,
  input  logic [IDX_SIZE:0]   len,
  output logic [IDX_SIZE-1:0] src_addr0,
  input  logic [WIDTH-1:0]    src_read_data,
  output logic [IDX_SIZE-1:0] dst_addr0,
  output logic [WIDTH-1:0]    dst_write_data,
  output logic                dst_write_en,
  input  logic                dst_done,
  output logic                done
);

  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT, FIN} state_t;

  state_t              state;
  logic [IDX_SIZE:0]   cnt;
  logic [IDX_SIZE:0]   cnt_inc;
  logic [IDX_SIZE:0]   len_q;
  logic [IDX_SIZE:0]   len_clamped;
  logic [IDX_SIZE-1:0] src_base_q;
  logic [IDX_SIZE-1:0] dst_base_q;

  function automatic logic [IDX_SIZE:0] clamp_len(input logic [IDX_SIZE:0] l);
    return (l > SIZE_W) ? SIZE_W : l;
  endfunction

  assign cnt_inc     = cnt + (IDX_SIZE+1)'(1);
  assign len_clamped = clamp_len(len);

  // Copy parameters are plain data captured at start; they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && go) begin
      src_base_q <= src_base;
      dst_base_q <= dst_base;
      len_q      <= len_clamped;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      src_addr0      <= '0;
      dst_addr0      <= '0;
      dst_write_data <= '0;
      dst_write_en   <= 1'b0;
      done           <= 1'b0;
    end else begin
      dst_write_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            cnt       <= '0;
            src_addr0 <= src_base;
            if (len_clamped == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          dst_write_data <= src_read_data;
          dst_addr0      <= dst_base_q + cnt[IDX_SIZE-1:0];
          dst_write_en   <= 1'b1;
          state          <= WRITE;
        end
        WRITE: state <= WAIT;
        WAIT: begin
          if (dst_done) begin
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              src_addr0 <= src_base_q + cnt_inc[IDX_SIZE-1:0];
              state     <= READ;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STD_MEM_COPY_CHECKS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == IDLE && go && len > SIZE_W)
        $error("std_mem_copy_d1: len %0d exceeds SIZE %0d", len, SIZE);
      if (state == READ && {1'b0, src_addr0} >= SIZE_W)
        $error("std_mem_copy_d1: src_addr0 %0d out of range", src_addr0);
      if (state == WRITE && {1'b0, dst_addr0} >= SIZE_W)
        $error("std_mem_copy_d1: dst_addr0 %0d out of range", dst_addr0);
      if (go && state != IDLE && state != FIN)
        $error("std_mem_copy_d1: go asserted while busy");
    end
  end
`endif

endmodule
